// File: rtl/lsu_if.sv
// Load/store unit bus: pipeline request/response plus the data-memory port.
interface lsu_if;
    // Pipeline side
    logic        start;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_read_type;
    logic [1:0]  mem_store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    // Data-memory side
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    // The LSU itself
    modport slave (
        input  start, mem_re, mem_we, mem_read_type, mem_store_type, addr, wdata,
        input  dmem_ready, dmem_rdata,
        output busy, done, rdata, err,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    // Pipeline + memory environment around the LSU
    modport master (
        output start, mem_re, mem_we, mem_read_type, mem_store_type, addr, wdata,
        output dmem_ready, dmem_rdata,
        input  busy, done, rdata, err,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one pipeline request becomes one or two word-aligned
// memory accesses; load bytes are reassembled and extended by type.
module load_store_unit #(
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter int unsigned TIMEOUT          = 16
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      r_state;
    logic        r_op;        // 1 = store
    logic [2:0]  r_rtype;
    logic [2:0]  r_size;      // 1, 2 or 4 bytes
    logic [1:0]  r_off;
    logic [29:0] r_wa;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;        // first word of a split load
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;
    logic        r_cross;
    logic        r_err;

    logic [2:0]  w_size;
    logic        w_type_ok;
    logic        w_cross;
    logic        w_legal;
    logic        w_can_accept;
    logic        w_acc;
    logic        w_tmo;
    logic [3:0]  w_mask;
    logic [4:0]  w_sh0;
    logic [5:0]  w_sh1;

    // Pick the extracted bytes out of {hi,lo} and extend by load type.
    function automatic logic [31:0] f_load(input logic [63:0] dw,
                                           input logic [1:0]  off,
                                           input logic [2:0]  rt);
        logic [31:0] s;
        s = dw[{off, 3'b000} +: 32];
        case (rt)
            3'b001:  return {{24{s[7]}}, s[7:0]};
            3'b010:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Request decode: size, type legality and word-boundary crossing.
    always_comb begin
        w_size    = 3'd0;
        w_type_ok = 1'b0;
        if (bus.mem_re) begin
            case (bus.mem_read_type)
                3'b001, 3'b100: begin w_size = 3'd1; w_type_ok = 1'b1; end
                3'b010, 3'b101: begin w_size = 3'd2; w_type_ok = 1'b1; end
                3'b011:         begin w_size = 3'd4; w_type_ok = 1'b1; end
                default:        ;
            endcase
        end else if (bus.mem_we) begin
            case (bus.mem_store_type)
                2'b01:   begin w_size = 3'd1; w_type_ok = 1'b1; end
                2'b10:   begin w_size = 3'd2; w_type_ok = 1'b1; end
                2'b11:   begin w_size = 3'd4; w_type_ok = 1'b1; end
                default: ;
            endcase
        end
        w_cross = ({1'b0, bus.addr[1:0]} + w_size) > 3'd4;
        w_legal = (bus.mem_re ^ bus.mem_we) & w_type_ok & ~(w_cross & ~SPLIT_MISALIGNED);
    end

    assign w_can_accept = (r_state == IDLE) || (r_state == DONE);
    assign w_acc        = (r_state == ACC0) || (r_state == ACC1);
    assign w_tmo        = (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);
    assign w_mask       = (r_size == 3'd4) ? 4'hF : (r_size == 3'd2) ? 4'h3 : 4'h1;
    assign w_sh0        = {r_off, 3'b000};
    assign w_sh1        = 6'd32 - {1'b0, w_sh0};

    assign bus.busy  = (bus.start & w_legal & w_can_accept) | w_acc;
    assign bus.done  = (r_state == DONE);
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;

    // Memory port: low half of the span in ACC0, spill-over bytes in ACC1.
    always_comb begin
        bus.dmem_req   = w_acc;
        bus.dmem_we    = w_acc & r_op;
        bus.dmem_addr  = 32'd0;
        bus.dmem_be    = 4'd0;
        bus.dmem_wdata = 32'd0;
        if (r_state == ACC0) begin
            bus.dmem_addr  = {r_wa, 2'b00};
            bus.dmem_be    = w_mask << r_off;
            bus.dmem_wdata = r_wdata << w_sh0;
        end else if (r_state == ACC1) begin
            bus.dmem_addr  = {r_wa + 30'd1, 2'b00};
            bus.dmem_be    = w_mask >> (3'd4 - {1'b0, r_off});
            bus.dmem_wdata = r_wdata >> w_sh1;
        end
    end

    // Control FSM: accept, up to two accesses, done/err pulses, timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= 1'b0;
            r_rtype <= 3'd0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_wa    <= 30'd0;
            r_wdata <= 32'd0;
            r_lo    <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= 32'd0;
            r_cross <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (bus.start) begin
                        if (w_legal) begin
                            r_op    <= bus.mem_we;
                            r_rtype <= bus.mem_read_type;
                            r_size  <= w_size;
                            r_off   <= bus.addr[1:0];
                            r_wa    <= bus.addr[31:2];
                            r_wdata <= bus.wdata;
                            r_cross <= w_cross;
                            r_cnt   <= 32'd0;
                            r_state <= ACC0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    if (bus.dmem_ready) begin
                        r_lo  <= bus.dmem_rdata;
                        r_cnt <= 32'd0;
                        if (r_cross) begin
                            r_state <= ACC1;
                        end else begin
                            r_rdata <= r_op ? 32'd0
                                            : f_load({bus.dmem_rdata, bus.dmem_rdata}, r_off, r_rtype);
                            r_state <= DONE;
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ACC1: begin
                    if (bus.dmem_ready) begin
                        r_rdata <= r_op ? 32'd0 : f_load({bus.dmem_rdata, r_lo}, r_off, r_rtype);
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
